usb2_in_sched: RTL

IN-transaction scheduler for the USB 2.0 protocol layer. It turns a decoded IN token into one of three responses: a DATA0/DATA1 packet streamed from the selected endpoint's output buffer, a NAK, or a STALL. It then waits for the host handshake and on ACK advances the data toggle and re-arms the endpoint buffer. It sits between the packet layer (token decode/tx framing) and the protocol layer's `sel_endp`/`buf_out_*` endpoint mux, which it owns exclusively.

---
 rtl/usb2_in_sched.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/usb2_in_sched.sv
// IN-transaction scheduler: answers an IN token with DATA0/1, NAK or STALL,
// waits for the host ACK, then advances the toggle and re-arms the endpoint buffer.
module usb2_in_sched #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [15:0] IN_EP_MASK  = 16'h0003
) (
    input  logic       phy_clk,
    input  logic       reset_n,
    input  logic       tok_valid,
    input  logic [3:0] tok_endp,
    input  logic       hs_ack,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [1:0] tx_kind,
    output logic [7:0] tx_data,
    output logic       tx_last,
    output logic       tx_zlp,
    output logic [3:0] sel_endp,
    output logic [8:0] buf_out_addr,
    input  logic [7:0] buf_out_q,
    input  logic [9:0] buf_out_len,
    input  logic       buf_out_hasdata,
    output logic       buf_out_arm,
    input  logic       buf_out_arm_ack,
    input  logic [1:0] data_toggle,
    output logic       data_toggle_act,
    output logic       busy
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CHECK    = 3'd1;
    localparam logic [2:0] ST_HS       = 3'd2;
    localparam logic [2:0] ST_SEND     = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK = 3'd4;
    localparam logic [2:0] ST_ARM      = 3'd5;

    localparam logic [1:0]  KIND_NAK     = 2'd2;
    localparam logic [1:0]  KIND_STALL   = 2'd3;
    localparam logic [9:0]  MAX_LEN      = 10'd512;
    localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [3:0]  sel_endp_q, sel_endp_d;
    logic [1:0]  kind_q, kind_d;
    logic [9:0]  len_q, len_d;
    logic [9:0]  rd_cnt_q, rd_cnt_d;
    logic [9:0]  tx_cnt_q, tx_cnt_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [7:0]  fifo0_q, fifo0_d;
    logic [7:0]  fifo1_q, fifo1_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        toggle_act_q, toggle_act_d;

    logic        accept;
    logic        pop;
    logic        rd_en;
    logic [1:0]  occ;
    logic [1:0]  cnt_after_pop;
    logic        unused_toggle_hi;

    assign unused_toggle_hi = data_toggle[1];

    // Beat generation: HS is a single handshake beat, SEND drains the prefetch FIFO.
    always_comb begin
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_zlp   = 1'b0;
        if (state_q == ST_HS) begin
            tx_valid = 1'b1;
            tx_last  = 1'b1;
        end else if (state_q == ST_SEND) begin
            if (len_q == 10'd0) begin
                tx_valid = 1'b1;
                tx_zlp   = 1'b1;
                tx_last  = 1'b1;
            end else begin
                tx_valid = (fifo_cnt_q != 2'd0);
                tx_last  = tx_valid && (tx_cnt_q == len_q - 10'd1);
            end
        end
    end

    assign accept = tx_valid && tx_ready;
    assign pop    = accept && (state_q == ST_SEND) && (len_q != 10'd0);
    assign occ    = fifo_cnt_q + {1'b0, inflight_q};
    // At most two bytes are ever buffered or in flight; a pop frees a slot this cycle.
    assign rd_en  = (state_q == ST_SEND) && (rd_cnt_q != len_q) && ((occ != 2'd2) || pop);
    assign cnt_after_pop = pop ? fifo_cnt_q - 2'd1 : fifo_cnt_q;

    always_comb begin
        state_d      = state_q;
        sel_endp_d   = sel_endp_q;
        kind_d       = kind_q;
        len_d        = len_q;
        rd_cnt_d     = rd_cnt_q;
        tx_cnt_d     = tx_cnt_q;
        inflight_d   = inflight_q;
        fifo_cnt_d   = fifo_cnt_q;
        fifo0_d      = fifo0_q;
        fifo1_d      = fifo1_q;
        to_cnt_d     = to_cnt_q;
        toggle_act_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tok_valid) begin
                    sel_endp_d = tok_endp;
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                rd_cnt_d   = 10'd0;
                tx_cnt_d   = 10'd0;
                inflight_d = 1'b0;
                fifo_cnt_d = 2'd0;
                if (!IN_EP_MASK[sel_endp_q]) begin
                    kind_d  = KIND_STALL;
                    state_d = ST_HS;
                end else if (!buf_out_hasdata) begin
                    kind_d  = KIND_NAK;
                    state_d = ST_HS;
                end else begin
                    len_d   = (buf_out_len > MAX_LEN) ? MAX_LEN : buf_out_len;
                    kind_d  = {1'b0, data_toggle[0]};
                    state_d = ST_SEND;
                end
            end
            ST_HS: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                inflight_d = rd_en;
                if (rd_en) begin
                    rd_cnt_d = rd_cnt_q + 10'd1;
                end
                if (pop) begin
                    tx_cnt_d = tx_cnt_q + 10'd1;
                    fifo0_d  = fifo1_q;
                end
                fifo_cnt_d = cnt_after_pop;
                if (inflight_q) begin
                    if (cnt_after_pop == 2'd0) begin
                        fifo0_d = buf_out_q;
                    end else begin
                        fifo1_d = buf_out_q;
                    end
                    fifo_cnt_d = cnt_after_pop + 2'd1;
                end
                if (accept && tx_last) begin
                    to_cnt_d = 16'd0;
                    state_d  = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                to_cnt_d = to_cnt_q + 16'd1;
                if (hs_ack) begin
                    toggle_act_d = 1'b1;
                    state_d      = ST_ARM;
                end else if (to_cnt_q == TIMEOUT_LAST) begin
                    // Buffer stays armed so the host retry gets the same data.
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (buf_out_arm_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge phy_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sel_endp_q   <= 4'd0;
            kind_q       <= 2'd0;
            len_q        <= 10'd0;
            rd_cnt_q     <= 10'd0;
            tx_cnt_q     <= 10'd0;
            inflight_q   <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            fifo0_q      <= 8'd0;
            fifo1_q      <= 8'd0;
            to_cnt_q     <= 16'd0;
            toggle_act_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_endp_q   <= sel_endp_d;
            kind_q       <= kind_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            tx_cnt_q     <= tx_cnt_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo0_q      <= fifo0_d;
            fifo1_q      <= fifo1_d;
            to_cnt_q     <= to_cnt_d;
            toggle_act_q <= toggle_act_d;
        end
    end

    assign tx_kind         = kind_q;
    assign tx_data         = fifo0_q;
    assign sel_endp        = sel_endp_q;
    assign buf_out_addr    = rd_cnt_q[8:0];
    assign buf_out_arm     = (state_q == ST_ARM);
    assign data_toggle_act = toggle_act_q;
    assign busy            = (state_q != ST_IDLE);

endmodule
